ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit that replaces the single-register PC plus IF/ID fetch path with a request/response ROM interface and a DEPTH-entry prefetch queue. It issues in-order fetch requests, buffers returned instructions, and presents them to decode through a valid/ready handshake. A jump from ctrl flushes the queue and discards in-flight responses. The block sits between ctrl/decode and the instruction ROM in the riscv top level.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/ifu_fifo.sv | 52 +++++
 rtl/ifu_prefetch.sv | 119 +++++++++++
 tb/tb_ifu_prefetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared riscv constants: default widths, reset PC, NOP encoding and
// prefetch queue entry width.
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam int          ENTRY_W          = 32 + XLEN_DEFAULT;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush and occupancy count; register storage so the
// head word comes straight out of flops.
module ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit, so the difference is the occupancy.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: in-order ROM requests, DEPTH-entry prefetch queue,
// jump flush with stale-response discard. Optional IFU_MISALIGN_CHK_EN.
module ifu_prefetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            rom_req_o,
  output logic [XLEN-1:0] rom_addr_o,
  input  logic            rom_gnt_i,
  input  logic            rom_rvalid_i,
  input  logic [31:0]     rom_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
`ifdef IFU_MISALIGN_CHK_EN
  output logic            inst_misalign_o,
`endif
  output logic [XLEN-1:0] inst_addr_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int EW = (XLEN == XLEN_DEFAULT) ? ENTRY_W : 32 + XLEN;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   outstanding;
  logic [PW-1:0]   discard;
  logic [PW-1:0]   q_count;
  logic [PW-1:0]   a_count;
  logic            q_full, q_empty, a_full, a_empty;
  logic [EW-1:0]   q_rdata;
  logic [XLEN-1:0] a_rdata;
  logic [XLEN-1:0] jump_tgt;
  logic            fetch_block;
  logic            credit_ok, fire, accept, q_pop;

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign;

  assign jump_tgt        = jump_addr_i;
  assign fetch_block     = misalign;
  assign inst_misalign_o = misalign;

  always_ff @(posedge clk) begin
    if (!rstn)          misalign <= 1'b0;
    else if (jump_en_i) misalign <= (jump_addr_i[1:0] != 2'b00);
  end
`else
  assign jump_tgt    = jump_addr_i & ~XLEN'(3);
  assign fetch_block = 1'b0;
`endif

  // Credits cover both queued and in-flight words, so a response always fits.
  assign credit_ok    = ({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_W;
  assign rom_req_o    = rstn && credit_ok && !jump_en_i && !fetch_block;
  assign rom_addr_o   = fetch_pc;
  assign fire         = rom_req_o && rom_gnt_i;
  assign accept       = rom_rvalid_i && (discard == '0) && !jump_en_i;
  assign inst_valid_o = !q_empty && !jump_en_i;
  assign q_pop        = inst_valid_o && inst_ready_i;
  assign inst_o       = q_rdata[EW-1:XLEN];
  assign inst_addr_o  = q_rdata[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (jump_en_i) begin
      // Everything still in flight becomes stale; a response landing now is dropped too.
      fetch_pc    <= jump_tgt;
      outstanding <= outstanding - PW'(rom_rvalid_i);
      discard     <= outstanding - PW'(rom_rvalid_i);
    end else begin
      if (fire) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding + PW'(fire) - PW'(rom_rvalid_i);
      if (rom_rvalid_i && (discard != '0)) discard <= discard - PW'(1);
    end
  end

  ifu_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_inst_q (
    .clk   (clk),
    .rstn  (rstn),
    .push  (accept),
    .pop   (q_pop),
    .flush (jump_en_i),
    .wdata ({rom_rdata_i, a_rdata}),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  ifu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fire),
    .pop   (accept),
    .flush (jump_en_i),
    .wdata (fetch_pc),
    .rdata (a_rdata),
    .count (a_count),
    .full  (a_full),
    .empty (a_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) accept |-> (!q_full || q_pop));
  a_addr_room:   assert property (@(posedge clk) disable iff (!rstn) fire |-> !a_full);
  a_addr_avail:  assert property (@(posedge clk) disable iff (!rstn) accept |-> !a_empty);
  a_inflight:    assert property (@(posedge clk) disable iff (!rstn) a_count == (outstanding - discard));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a latency-configurable ROM responder.
// Define IFU_MISALIGN_CHK_EN to exercise the misaligned-jump feature.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_gnt_i;
  logic        rom_rvalid_i;
  logic [31:0] rom_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
`ifdef IFU_MISALIGN_CHK_EN
  logic        inst_misalign_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int cyc     = 0;
  int nreq;

  always #5 clk = ~clk;

  ifu_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_gnt_i    (rom_gnt_i),
    .rom_rvalid_i (rom_rvalid_i),
    .rom_rdata_i  (rom_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
`ifdef IFU_MISALIGN_CHK_EN
    .inst_misalign_o (inst_misalign_o),
`endif
    .inst_addr_o  (inst_addr_o)
  );

  function automatic logic [31:0] rom_word(logic [31:0] a);
    return ~a;
  endfunction

  // ROM: a request granted in cycle N answers in cycle N+lat, in order.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic        smp_fire;
  logic [31:0] smp_addr;
  initial begin
    rom_rvalid_i = 1'b0;
    rom_rdata_i  = '0;
    forever begin
      @(negedge clk);
      smp_fire = rom_req_o && rom_gnt_i;
      smp_addr = rom_addr_o;
      @(posedge clk);
      cyc++;
      #1;
      if (smp_fire) begin
        pend_addr.push_back(smp_addr);
        pend_due.push_back(cyc - 1 + lat);
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        rom_rvalid_i = 1'b1;
        rom_rdata_i  = rom_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0;
    rom_gnt_i = 1'b1; inst_ready_i = 1'b1;

    // Reset state
    mid();
    chk("rst_req",   rom_req_o, 0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_inst",  inst_o, 0);
    chk("rst_iaddr", inst_addr_o, 0);
`ifdef IFU_MISALIGN_CHK_EN
    chk("rst_misalign", inst_misalign_o, 0);
`endif

    // Zero-wait streaming from reset
    next(); rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next();
      mid();
      chk("b_req",   rom_req_o, 1);
      chk("b_addr",  rom_addr_o, 32'(4*k));
      chk("b_valid", inst_valid_o, 32'(k >= 2));
      if (k >= 2) begin
        chk("b_iaddr", inst_addr_o, 32'(4*(k-2)));
        chk("b_inst",  inst_o, ~32'(4*(k-2)));
      end
    end

    // Grant held low: address and fetch_pc frozen
    next(); rom_gnt_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) next();
      mid();
      chk("c_req",  rom_req_o, 1);
      chk("c_addr", rom_addr_o, 32'h18);
      if (k == 1) chk("c_iaddr", inst_addr_o, 32'h14);
    end
    next(); rom_gnt_i = 1'b1;
    mid(); chk("c_gnt_addr", rom_addr_o, 32'h18);
    next(); mid();
    chk("c_addr2", rom_addr_o, 32'h1c);
    chk("c_valid0", inst_valid_o, 0);
    next(); mid();
    chk("c_valid1", inst_valid_o, 1);
    chk("c_iaddr2", inst_addr_o, 32'h18);

    // Drain, then re-reset with decode stalled
    next(); rom_gnt_i = 1'b0;
    repeat (3) next();
    inst_ready_i = 1'b0; rstn = 1'b0;
    next(); rstn = 1'b1; rom_gnt_i = 1'b1;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) next();
      mid();
      nreq += int'(rom_req_o);
    end
    chk("d_nreq",  32'(nreq), 4);
    chk("d_req9",  rom_req_o, 0);
    chk("d_head9", inst_addr_o, 32'h0);
    for (int i = 10; i < 15; i++) begin
      next(); inst_ready_i = 1'b1;
      mid();
      chk("d_valid", inst_valid_o, 1);
      chk("d_iaddr", inst_addr_o, 32'(4*(i-10)));
      chk("d_inst",  inst_o, ~32'(4*(i-10)));
      if (i == 10) chk("d_full_req", rom_req_o, 0);
      if (i == 11) chk("d_resume_addr", rom_addr_o, 32'h10);
    end

    // Drain, then 3-cycle ROM with two stale requests at the jump
    next(); rom_gnt_i = 1'b0;
    repeat (3) next();
    lat = 3; jump_en_i = 1'b1; jump_addr_i = 32'h40;
    mid();
    chk("e_jreq",   rom_req_o, 0);
    chk("e_jvalid", inst_valid_o, 0);
    next(); jump_en_i = 1'b0; rom_gnt_i = 1'b1;
    mid(); chk("e_addr40", rom_addr_o, 32'h40);
    next(); mid(); chk("e_addr44", rom_addr_o, 32'h44);
    next(); jump_en_i = 1'b1; jump_addr_i = 32'h100;
    mid(); chk("e_jreq2", rom_req_o, 0);
    next(); jump_en_i = 1'b0;
    mid();
    chk("e_req100",  rom_req_o, 1);
    chk("e_addr100", rom_addr_o, 32'h100);
    chk("e_valid_t4", inst_valid_o, 0);
    for (int k = 0; k < 3; k++) begin
      next(); mid();
      chk("e_stale_valid", inst_valid_o, 0);
    end
    next(); mid();
    chk("e_valid",  inst_valid_o, 1);
    chk("e_iaddr",  inst_addr_o, 32'h100);
    chk("e_inst",   inst_o, ~32'h100);

    // Drain, then jump in the same cycle as a response and a ready head
    next(); rom_gnt_i = 1'b0;
    repeat (4) next();
    lat = 1; jump_en_i = 1'b1; jump_addr_i = 32'h300;
    next(); jump_en_i = 1'b0; rom_gnt_i = 1'b1;
    mid(); chk("f_addr300", rom_addr_o, 32'h300);
    next(); mid(); chk("f_addr304", rom_addr_o, 32'h304);
    next(); jump_en_i = 1'b1; jump_addr_i = 32'h500;
    mid();
    chk("f_rvalid_in_jump", rom_rvalid_i, 1);
    chk("f_jvalid",   inst_valid_o, 0);
    chk("f_jhead",    inst_addr_o, 32'h300);
    chk("f_jreq",     rom_req_o, 0);
    next(); jump_en_i = 1'b0;
    mid();
    chk("f_addr500", rom_addr_o, 32'h500);
    chk("f_valid1",  inst_valid_o, 0);
    next(); mid(); chk("f_valid2", inst_valid_o, 0);
    next(); mid();
    chk("f_valid3", inst_valid_o, 1);
    chk("f_iaddr",  inst_addr_o, 32'h500);
    chk("f_inst",   inst_o, ~32'h500);

`ifdef IFU_MISALIGN_CHK_EN
    next(); jump_en_i = 1'b1; jump_addr_i = 32'h102;
    next(); jump_en_i = 1'b0;
    mid();
    chk("g_flag",  inst_misalign_o, 1);
    chk("g_noreq", rom_req_o, 0);
    next(); mid();
    chk("g_noreq2", rom_req_o, 0);
    chk("g_novalid", inst_valid_o, 0);
    next(); jump_en_i = 1'b1; jump_addr_i = 32'h200;
    mid(); chk("g_flag_held", inst_misalign_o, 1);
    next(); jump_en_i = 1'b0;
    mid();
    chk("g_flag_clr", inst_misalign_o, 0);
    chk("g_req",      rom_req_o, 1);
    chk("g_addr",     rom_addr_o, 32'h200);
`else
    next(); jump_en_i = 1'b1; jump_addr_i = 32'h602;
    next(); jump_en_i = 1'b0;
    mid();
    chk("g_align_req",  rom_req_o, 1);
    chk("g_align_addr", rom_addr_o, 32'h600);
`endif

    repeat (3) next();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
